cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 20 ++
 rtl/cdb_arbiter_rr_arbiter.sv | 36 +++
 rtl/cdb_arbiter.sv | 114 +++++++++++
 tb/tb_cdb_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions (XLEN, FU count, broadcast packet) used by the arbiter,
// reservation stations and ROB.
package cdb_arbiter_pkg;

   localparam int XLEN       = 32;
   localparam int DEF_NUM_FU = 4;
   localparam int DEF_TAG_W  = 5;

   typedef struct packed {
      logic                 valid;
      logic [DEF_TAG_W-1:0] tag;
      logic [XLEN-1:0]      value;
   } cdb_packet_t;

   // Index width that stays legal for a single-entry arbiter.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo N.
module rr_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] index
);

   logic found;
   int   j;

   // Scan N positions starting at ptr; the first hit wins.
   always_comb begin
      grant = '0;
      index = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!found && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            index    = IW'(j);
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding register per functional unit, a
// round-robin grant each cycle, and a registered broadcast to RS/ROB.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter  int NUM_FU = DEF_NUM_FU,
   parameter  int TAG_W  = DEF_TAG_W,
   localparam int IW     = idx_w(NUM_FU)
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             flush,
   input  logic [NUM_FU-1:0]                fu_done_valid,
   input  logic [NUM_FU-1:0][TAG_W-1:0]     fu_done_tag,
   input  logic [NUM_FU-1:0][XLEN-1:0]      fu_done_value,
   output logic [NUM_FU-1:0]                fu_done_ready,
   output logic                             cdb_valid,
   output logic [TAG_W-1:0]                 cdb_tag,
   output logic [XLEN-1:0]                  cdb_value,
   output logic [IW-1:0]                    cdb_fu_idx
);

   logic [NUM_FU-1:0]            hold_valid_q, hold_valid_d;
   logic [NUM_FU-1:0][TAG_W-1:0] hold_tag_q,   hold_tag_d;
   logic [NUM_FU-1:0][XLEN-1:0]  hold_value_q, hold_value_d;
   logic [IW-1:0]                rr_ptr_q,     rr_ptr_d;
   logic                         cdb_valid_q,  cdb_valid_d;
   logic [TAG_W-1:0]             cdb_tag_q,    cdb_tag_d;
   logic [XLEN-1:0]              cdb_value_q,  cdb_value_d;
   logic [IW-1:0]                cdb_idx_q,    cdb_idx_d;

   logic [NUM_FU-1:0] grant;
   logic [IW-1:0]     grant_idx;
   logic              grant_any;
   logic [NUM_FU-1:0] accept;

   rr_arbiter #(.N(NUM_FU)) u_rr (
      .req   (hold_valid_q),
      .ptr   (rr_ptr_q),
      .grant (grant),
      .index (grant_idx)
   );

   assign grant_any = |grant;
   // A granted slot drains this edge, so it can be refilled in the same edge.
   assign fu_done_ready = {NUM_FU{~flush}} & (~hold_valid_q | grant);
   assign accept        = fu_done_valid & fu_done_ready;

   // Next-state: load on handshake, drain on grant, squash on flush.
   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_tag_d   = hold_tag_q;
      hold_value_d = hold_value_q;
      rr_ptr_d     = rr_ptr_q;
      cdb_valid_d  = cdb_valid_q;
      cdb_tag_d    = cdb_tag_q;
      cdb_value_d  = cdb_value_q;
      cdb_idx_d    = cdb_idx_q;
      if (flush) begin
         hold_valid_d = '0;
         cdb_valid_d  = 1'b0;
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (accept[i]) begin
               hold_valid_d[i] = 1'b1;
               hold_tag_d[i]   = fu_done_tag[i];
               hold_value_d[i] = fu_done_value[i];
            end else if (grant[i]) begin
               hold_valid_d[i] = 1'b0;
            end else begin
               hold_valid_d[i] = hold_valid_q[i];
            end
         end
         cdb_valid_d = grant_any;
         if (grant_any) begin
            cdb_tag_d   = hold_tag_q[grant_idx];
            cdb_value_d = hold_value_q[grant_idx];
            cdb_idx_d   = grant_idx;
            rr_ptr_d    = (grant_idx == IW'(NUM_FU - 1)) ? '0 : grant_idx + IW'(1);
         end else begin
            rr_ptr_d = rr_ptr_q;
         end
      end
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hold_valid_q <= '0;
         hold_tag_q   <= '0;
         hold_value_q <= '0;
         rr_ptr_q     <= '0;
         cdb_valid_q  <= 1'b0;
         cdb_tag_q    <= '0;
         cdb_value_q  <= '0;
         cdb_idx_q    <= '0;
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_tag_q   <= hold_tag_d;
         hold_value_q <= hold_value_d;
         rr_ptr_q     <= rr_ptr_d;
         cdb_valid_q  <= cdb_valid_d;
         cdb_tag_q    <= cdb_tag_d;
         cdb_value_q  <= cdb_value_d;
         cdb_idx_q    <= cdb_idx_d;
      end
   end

   assign cdb_valid  = cdb_valid_q;
   assign cdb_tag    = cdb_tag_q;
   assign cdb_value  = cdb_value_q;
   assign cdb_fu_idx = cdb_idx_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: expected broadcasts are queued as stimulus
// is driven and popped as the CDB fires.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int N  = 4;
   localparam int TW = 5;

   logic                    clock = 1'b0;
   logic                    reset = 1'b1;
   logic                    flush = 1'b0;
   logic [N-1:0]            fu_done_valid = '0;
   logic [N-1:0][TW-1:0]    fu_done_tag   = '0;
   logic [N-1:0][XLEN-1:0]  fu_done_value = '0;
   logic [N-1:0]            fu_done_ready;
   logic                    cdb_valid;
   logic [TW-1:0]           cdb_tag;
   logic [XLEN-1:0]         cdb_value;
   logic [1:0]              cdb_fu_idx;

   typedef struct packed {
      cdb_packet_t pkt;
      logic [1:0]  fu;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   cdb_arbiter #(.NUM_FU(N), .TAG_W(TW)) dut (
      .clock         (clock),
      .reset         (reset),
      .flush         (flush),
      .fu_done_valid (fu_done_valid),
      .fu_done_tag   (fu_done_tag),
      .fu_done_value (fu_done_value),
      .fu_done_ready (fu_done_ready),
      .cdb_valid     (cdb_valid),
      .cdb_tag       (cdb_tag),
      .cdb_value     (cdb_value),
      .cdb_fu_idx    (cdb_fu_idx)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, got, exp);
      end
   endtask

   task automatic expect_bc(input logic [1:0] fu, input logic [4:0] tag, input logic [31:0] val);
      exp_t e;
      e.pkt.valid = 1'b1;
      e.pkt.tag   = tag;
      e.pkt.value = val;
      e.fu        = fu;
      sb_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_fu(input int i, input logic v, input logic [4:0] t, input logic [31:0] d);
      fu_done_valid[i] = v;
      fu_done_tag[i]   = t;
      fu_done_value[i] = d;
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      flush         = 1'b0;
      fu_done_valid = '0;
      step();
      step();
      reset = 1'b0;
      sb_q.delete();
   endtask

   task automatic drain(input int n);
      repeat (n) step();
      check("sb_empty", 64'(sb_q.size()), 64'd0);
   endtask

   // Every broadcast must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (!reset && cdb_valid) begin
         if (sb_q.size() == 0) begin
            check("unexpected_bcast_tag", 64'(cdb_tag), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("cdb_tag",    64'(cdb_tag),    64'(e.pkt.tag));
            check("cdb_value",  64'(cdb_value),  64'(e.pkt.value));
            check("cdb_fu_idx", 64'(cdb_fu_idx), 64'(e.fu));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, errors=%0d", n_errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int i0, i2, st0, st2, max0, max2;
      logic a0, a2;

      // Reset state
      step();
      step();
      @(negedge clock);
      check("rst_cdb_valid", 64'(cdb_valid),  64'd0);
      check("rst_cdb_tag",   64'(cdb_tag),    64'd0);
      check("rst_cdb_value", 64'(cdb_value),  64'd0);
      check("rst_cdb_idx",   64'(cdb_fu_idx), 64'd0);
      reset = 1'b0;
      #1;
      check("rst_ready", 64'(fu_done_ready), 64'hF);
      step();

      // Single result: 2-edge latency, then low with held payload
      set_fu(1, 1'b1, 5'd7, 32'h0000_00AA);
      expect_bc(2'd1, 5'd7, 32'h0000_00AA);
      step();
      set_fu(1, 1'b0, 5'd0, 32'h0);
      @(negedge clock);
      check("s1_latency_valid", 64'(cdb_valid), 64'd0);
      step();
      step();
      @(negedge clock);
      check("s1_low_valid", 64'(cdb_valid),  64'd0);
      check("s1_hold_tag",  64'(cdb_tag),    64'd7);
      check("s1_hold_val",  64'(cdb_value),  64'hAA);
      check("s1_hold_idx",  64'(cdb_fu_idx), 64'd1);
      step();
      drain(2);

      // All four at once: order 1,2,3,4 and ready returning in grant cycle
      do_reset();
      for (int i = 0; i < N; i++) begin
         set_fu(i, 1'b1, 5'(i + 1), 32'h100 + 32'(i));
         expect_bc(2'(i), 5'(i + 1), 32'h100 + 32'(i));
      end
      step();
      fu_done_valid = '0;
      for (int k = 0; k < N; k++) begin
         @(negedge clock);
         check("s2_ready", 64'(fu_done_ready), 64'((1 << (k + 1)) - 1));
         step();
      end
      drain(3);

      // Fairness: FU0 and FU2 offering back-to-back
      do_reset();
      for (int k = 0; k < 3; k++) begin
         expect_bc(2'd0, 5'(10 + k), 32'h1000 + 32'(k));
         expect_bc(2'd2, 5'(20 + k), 32'h2000 + 32'(k));
      end
      i0 = 0; i2 = 0; st0 = 0; st2 = 0; max0 = 0; max2 = 0;
      for (int c = 0; c < 12; c++) begin
         set_fu(0, i0 < 3, 5'(10 + i0), 32'h1000 + 32'(i0));
         set_fu(2, i2 < 3, 5'(20 + i2), 32'h2000 + 32'(i2));
         @(negedge clock);
         a0 = fu_done_valid[0] && fu_done_ready[0];
         a2 = fu_done_valid[2] && fu_done_ready[2];
         st0 = (fu_done_valid[0] && !fu_done_ready[0]) ? st0 + 1 : 0;
         st2 = (fu_done_valid[2] && !fu_done_ready[2]) ? st2 + 1 : 0;
         if (st0 > max0) max0 = st0;
         if (st2 > max2) max2 = st2;
         step();
         if (a0) i0++;
         if (a2) i2++;
      end
      fu_done_valid = '0;
      check("s3_max_stall0", 64'(max0), 64'd1);
      check("s3_max_stall2", 64'(max2), 64'd1);
      check("s3_accepted0",  64'(i0),   64'd3);
      check("s3_accepted2",  64'(i2),   64'd3);
      drain(2);

      // Backpressure: FU3 waits behind three winners
      do_reset();
      set_fu(0, 1'b1, 5'd30, 32'h300);
      set_fu(1, 1'b1, 5'd31, 32'h310);
      set_fu(2, 1'b1, 5'd28, 32'h320);
      set_fu(3, 1'b1, 5'h1F, 32'hDEAD_BEEF);
      expect_bc(2'd0, 5'd30, 32'h300);
      expect_bc(2'd1, 5'd31, 32'h310);
      expect_bc(2'd2, 5'd28, 32'h320);
      expect_bc(2'd3, 5'h1F, 32'hDEAD_BEEF);
      step();
      for (int i = 0; i < 3; i++) set_fu(i, 1'b0, 5'd0, 32'h0);
      set_fu(3, 1'b1, 5'h1E, 32'hCAFE_F00D);
      expect_bc(2'd3, 5'h1E, 32'hCAFE_F00D);
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         check("s4_ready3", 64'(fu_done_ready[3]), 64'(k == 3));
         step();
      end
      set_fu(3, 1'b0, 5'd0, 32'h0);
      drain(3);

      // Flush with entries 0 and 2 held and FU1 handshaking
      do_reset();
      set_fu(0, 1'b1, 5'd19, 32'h390);
      expect_bc(2'd0, 5'd19, 32'h390);
      step();
      set_fu(0, 1'b1, 5'd24, 32'h400);
      set_fu(2, 1'b1, 5'd26, 32'h420);
      @(negedge clock);
      check("s5_ready_pre", 64'(fu_done_ready), 64'hF);
      step();
      set_fu(0, 1'b0, 5'd0, 32'h0);
      set_fu(2, 1'b0, 5'd0, 32'h0);
      set_fu(1, 1'b1, 5'd25, 32'h410);
      flush = 1'b1;
      @(negedge clock);
      check("s5_ready_flush", 64'(fu_done_ready), 64'h0);
      step();
      flush = 1'b0;
      set_fu(1, 1'b0, 5'd0, 32'h0);
      @(negedge clock);
      check("s5_ready_post", 64'(fu_done_ready), 64'hF);
      check("s5_valid_post", 64'(cdb_valid),     64'd0);
      step();
      step();
      step();
      // rr_ptr must still be 1 after the flush, so FU1 goes before FU0
      set_fu(0, 1'b1, 5'd20, 32'h500);
      set_fu(1, 1'b1, 5'd21, 32'h510);
      expect_bc(2'd1, 5'd21, 32'h510);
      expect_bc(2'd0, 5'd20, 32'h500);
      step();
      fu_done_valid = '0;
      drain(4);

      // Reset while broadcasting tag 9 with FU3 still held
      do_reset();
      set_fu(2, 1'b1, 5'd9,  32'h999);
      set_fu(3, 1'b1, 5'd10, 32'hA0A);
      expect_bc(2'd2, 5'd9,  32'h999);
      expect_bc(2'd3, 5'd10, 32'hA0A);
      step();
      fu_done_valid = '0;
      step();
      @(negedge clock);
      #2;
      reset = 1'b1;
      #1;
      check("s6_valid_drop", 64'(cdb_valid), 64'd0);
      sb_q.delete();
      step();
      step();
      reset = 1'b0;
      @(negedge clock);
      check("s6_ready_post", 64'(fu_done_ready), 64'hF);
      check("s6_valid_post", 64'(cdb_valid),     64'd0);
      step();
      step();
      step();
      set_fu(1, 1'b1, 5'd11, 32'hB0B);
      expect_bc(2'd1, 5'd11, 32'hB0B);
      step();
      fu_done_valid = '0;
      drain(3);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
